game_sequencer: RTL
===================

# game_sequencer

Round sequencer for the memory matrix game. It takes the start key, the eight tile buttons and the solution board from the board generator, and steps through each round: idle, solution display, guessing, then win or lose. It drives the `ld_start`, `ld_display`, `ld_play` and `ld_flash` enables that configure the display and datapath. It also owns the found-tile register and the wrong-guess budget, so the datapath only renders what this block reports.

## Interface
- `TICK_DIV`, default 50000000: clock cycles per display tick. Must be ≥ 2.
- `SHOW_TICKS`, default 2: number of ticks the solution is shown. Must be ≥ 1.
- `clk` in 1: system clock. All state updates on its rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-high. It forces every register to its reset value immediately.
- `start` in 1: start key, active-high, already debounced and synchronised.
- `buttons` in 8: tile buttons, level, active-high, already synchronised.
- `solution` in 8: solution board. Held stable by the board generator outside IDLE.
- `guess_limit` in 4: wrong-guess budget, sampled on the IDLE→ARM transition.
- `ld_start` out 1: clear current board / idle indication.
- `ld_display` out 1: show the full solution.
- `ld_play` out 1: guessing phase active.
- `ld_flash` out 1: flash LED enable.
- `found` out 8: tiles correctly guessed this round.
- `misses_left` out 4: remaining wrong guesses.
- `guess_valid` out 1: one-cycle pulse after an accepted guess.
- `guess_hit` out 1: qualifies `guess_valid`; 1 means the guess was correct.
- `win` out 1: level, high in state WIN.
- `lose` out 1: level, high in state LOSE.

## Operation
- **States:** IDLE, ARM, SHOW, PLAY, WIN, LOSE, END_ARM. State is registered; all `ld_*`, `win` and `lose` are Moore decodes of the state.
- **IDLE**
  - Outputs: `ld_start`=1, `ld_flash`=1.
  - `start`=1 → ARM. On that edge: `found`←0 and `misses_left`←`guess_limit`, with `guess_limit`=0 loaded as 1.
- **ARM**
  - Outputs: `ld_start`=1.
  - `start`=0 → SHOW. On that edge the tick prescaler and tick counter clear to 0.
- **SHOW**
  - Outputs: `ld_display`=1.
  - The prescaler counts 0..TICK_DIV-1 and wraps. The tick counter increments on each wrap.
  - When the tick counter reaches SHOW_TICKS-1 and the prescaler reaches TICK_DIV-1 → PLAY.
  - SHOW therefore lasts exactly SHOW_TICKS×TICK_DIV cycles.
  - If `solution`==0 on SHOW entry: → WIN after the same duration.
- **PLAY**
  - Outputs: `ld_play`=1.
  - A rise is `buttons & ~buttons_q`, where `buttons_q` is the registered previous `buttons` (it samples every cycle in every state).
  - A guess is accepted only when the rise vector has exactly one bit set. Zero bits or multiple simultaneous bits → ignored, no counter change.
  - Accepted bit already in `found` → ignored, no penalty, no `guess_valid`.
  - Hit (bit & `solution` ≠ 0): `found` |= bit. If the new `found` == `solution` → WIN on the same edge.
  - Miss: `misses_left` −1. If it becomes 0 → LOSE on the same edge.
  - Held buttons never re-trigger.
- **WIN / LOSE**
  - Outputs: `ld_flash`=1, plus `win` or `lose` respectively.
  - LOSE additionally asserts `ld_display`=1, so the solution is revealed.
  - `start`=1 → END_ARM.
- **END_ARM**
  - Outputs: `ld_flash`=1.
  - `start`=0 → IDLE.
- **Ignored inputs:** `start` is ignored in SHOW and PLAY. Button activity outside PLAY is ignored, though `buttons_q` still tracks.
- **Arithmetic:** `misses_left` never underflows; it stops at 0 because LOSE is entered there. The prescaler width is clog2(TICK_DIV).

## Timing
- **Reset values:**
  - state = IDLE, so `ld_start`=1, `ld_flash`=1 and the other `ld_*` are 0.
  - `found`=0, `misses_left`=0, `guess_valid`=0, `guess_hit`=0, `win`=0, `lose`=0, `buttons_q`=0.
  - Prescaler and tick counter = 0.
- **Latency:**
  - A button rise sampled at edge k updates `found`/`misses_left` and the state at edge k+1.
  - `guess_valid`/`guess_hit` are high during the cycle after edge k+1, for exactly one cycle.
- **Transitions:** all state transitions take effect one edge after their condition is true. Enables change in the same cycle as the state.
- **Reset mid-round:** asynchronous return to IDLE with reset values. No pending pulse survives.

## Test plan
- **Reset:** assert `reset` mid-PLAY with `found`=8'h05 → immediately state IDLE, `found`=0, `ld_start`=1, `guess_valid`=0.
- **SHOW duration:** TICK_DIV=4, SHOW_TICKS=2, `guess_limit`=3 → press and release `start` → `ld_display` high for exactly 8 cycles, then `ld_play`=1 and `misses_left`=3.
- **Win:** `solution`=8'h21. Press bit5 → `found`=8'h20, `guess_valid`=1, `guess_hit`=1. Press bit0 → `found`=8'h21, `win`=1, `ld_flash`=1.
- **Lose:** `solution`=8'h01, `guess_limit`=2. Press bit3, then bit4 → `misses_left` goes 2→1→0, `lose`=1, `ld_display`=1. Press `start`, release → IDLE.
- **Ignored presses:** bits 2 and 6 rising in the same cycle → no change. Hold bit0 (a hit) for 10 cycles → one `guess_valid` only. Re-press bit0 → ignored, `misses_left` unchanged.
- **Zero limit and zero solution:** `guess_limit`=0 → `misses_left` loads 1 and the first miss → LOSE. `solution`=0 → SHOW→WIN without entering PLAY.

Source files
------------

// File: rtl/game_sequencer.sv
// Round sequencer for the memory matrix game: start/show/guess/win-lose flow,
// found-tile register and wrong-guess budget.
module game_sequencer #(
  parameter int TICK_DIV   = 50000000,
  parameter int SHOW_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] buttons,
  input  logic [7:0] solution,
  input  logic [3:0] guess_limit,
  output logic       ld_start,
  output logic       ld_display,
  output logic       ld_play,
  output logic       ld_flash,
  output logic [7:0] found,
  output logic [3:0] misses_left,
  output logic       guess_valid,
  output logic       guess_hit,
  output logic       win,
  output logic       lose
);

  // state   | meaning
  // IDLE    | waiting for start, board cleared
  // ARM     | start held, waiting for release
  // SHOW    | solution displayed for SHOW_TICKS ticks
  // PLAY    | accepting tile guesses
  // WIN     | all solution tiles found
  // LOSE    | guess budget exhausted, solution revealed
  // END_ARM | start held after a finished round, waiting for release

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = (SHOW_TICKS > 1) ? $clog2(SHOW_TICKS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SHOW_TICKS - 1);

  typedef enum logic [2:0] {IDLE, ARM, SHOW, PLAY, WIN, LOSE, END_ARM} state_t;

  typedef struct packed {
    logic ld_start;
    logic ld_display;
    logic ld_play;
    logic ld_flash;
    logic win;
    logic lose;
  } outs_t;

  // Outputs are registered together with the state they belong to.
  function automatic outs_t decode(input state_t s);
    outs_t o;
    o = '0;
    case (s)
      IDLE:    begin o.ld_start = 1'b1; o.ld_flash = 1'b1; end
      ARM:     o.ld_start = 1'b1;
      SHOW:    o.ld_display = 1'b1;
      PLAY:    o.ld_play = 1'b1;
      WIN:     begin o.ld_flash = 1'b1; o.win = 1'b1; end
      LOSE:    begin o.ld_flash = 1'b1; o.lose = 1'b1; o.ld_display = 1'b1; end
      END_ARM: o.ld_flash = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  state_t        state;
  outs_t         outs;
  logic [PW-1:0] prescale;
  logic [TW-1:0] tick_cnt;
  logic          sol_zero;
  logic [7:0]    buttons_q;
  logic [7:0]    rise;
  logic [7:0]    found_next;
  logic          accept;
  logic          hit;

  assign rise       = buttons & ~buttons_q;
  assign found_next = found | rise;
  assign accept     = $onehot(rise) && ((rise & found) == 8'h00);
  assign hit        = (rise & solution) != 8'h00;

  assign ld_start   = outs.ld_start;
  assign ld_display = outs.ld_display;
  assign ld_play    = outs.ld_play;
  assign ld_flash   = outs.ld_flash;
  assign win        = outs.win;
  assign lose       = outs.lose;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      outs        <= decode(IDLE);
      found       <= 8'h00;
      misses_left <= 4'd0;
      guess_valid <= 1'b0;
      guess_hit   <= 1'b0;
      buttons_q   <= 8'h00;
      prescale    <= '0;
      tick_cnt    <= '0;
      sol_zero    <= 1'b0;
    end else begin
      buttons_q   <= buttons;
      guess_valid <= 1'b0;
      guess_hit   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= ARM;
            outs        <= decode(ARM);
            found       <= 8'h00;
            misses_left <= (guess_limit == 4'd0) ? 4'd1 : guess_limit;
          end
        end
        ARM: begin
          if (!start) begin
            state    <= SHOW;
            outs     <= decode(SHOW);
            prescale <= '0;
            tick_cnt <= '0;
            sol_zero <= (solution == 8'h00);
          end
        end
        SHOW: begin
          if (tick_cnt == TICK_LAST && prescale == PRE_LAST) begin
            // An empty board is already solved, so skip guessing entirely.
            if (sol_zero) begin
              state <= WIN;
              outs  <= decode(WIN);
            end else begin
              state <= PLAY;
              outs  <= decode(PLAY);
            end
          end else if (prescale == PRE_LAST) begin
            prescale <= '0;
            tick_cnt <= tick_cnt + 1'b1;
          end else begin
            prescale <= prescale + 1'b1;
          end
        end
        PLAY: begin
          if (accept) begin
            guess_valid <= 1'b1;
            guess_hit   <= hit;
            if (hit) begin
              found <= found_next;
              if (found_next == solution) begin
                state <= WIN;
                outs  <= decode(WIN);
              end
            end else begin
              misses_left <= misses_left - 4'd1;
              if (misses_left == 4'd1) begin
                state <= LOSE;
                outs  <= decode(LOSE);
              end
            end
          end
        end
        WIN, LOSE: begin
          if (start) begin
            state <= END_ARM;
            outs  <= decode(END_ARM);
          end
        end
        END_ARM: begin
          if (!start) begin
            state <= IDLE;
            outs  <= decode(IDLE);
          end
        end
        default: begin
          state <= IDLE;
          outs  <= decode(IDLE);
        end
      endcase
    end
  end

endmodule
